ntt_poly_io: RTL and testbench

Streaming front/back end for the NTT datapath. It accepts one polynomial of N coefficients on a valid/ready input stream and reduces each coefficient into [0, Q). It writes them into BRAM bank 0 and pulses the NTT controller's enable with the requested mode. After the controller reports done, it reads the result bank and streams the N transformed coefficients out with backpressure. It sits between the system interconnect and the NTT controller, owning the BRAM port-A path only while loading or unloading.

---
 rtl/ntt_poly_io.sv | 190 +++++++++++++++++++
 tb/tb_ntt_poly_io.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_poly_io.sv
// rtl/ntt_poly_io.sv - NTT polynomial load/unload streaming front end
module ntt_poly_io #(
    parameter int N          = 4,
    parameter int ADDR_WIDTH = $clog2(N),
    parameter int DATA_WIDTH = 12,
    parameter int Q          = 3329
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_start,
    input  logic                  op_mode,
    input  logic                  op_result_bank,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  ntt_enable,
    output logic                  ntt_mode,
    input  logic                  ntt_done,
    output logic                  bram_owner,
    output logic                  io_bank,
    output logic [ADDR_WIDTH-1:0] io_addr,
    output logic                  io_we,
    output logic [DATA_WIDTH-1:0] io_din,
    input  logic [DATA_WIDTH-1:0] io_dout0,
    input  logic [DATA_WIDTH-1:0] io_dout1,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  op_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
    localparam logic [DATA_WIDTH-1:0] Q_VAL     = DATA_WIDTH'(Q);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_UNLOAD} state_t;

    state_t                state;
    logic                  mode_q;
    logic                  bank_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  load_last;
    logic                  rd_pend;
    logic                  pend_last;
    logic                  rd_done;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_last [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;

    logic [DATA_WIDTH-1:0] s_red;
    logic [DATA_WIDTH-1:0] dout_sel;
    logic                  fifo_empty;
    logic                  beat;
    logic                  issue;
    logic                  push;
    logic                  pop;

    assign s_red      = (s_data >= Q_VAL) ? s_data - Q_VAL : s_data;
    assign dout_sel   = bank_q ? io_dout1 : io_dout0;
    assign fifo_empty = (fifo_cnt == 2'd0);

    // Read data returning this cycle is presented directly when the FIFO is
    // empty, so the first beat appears one cycle after its read issues.
    assign m_valid = !fifo_empty || rd_pend;
    assign m_data  = !fifo_empty ? fifo_data[rd_ptr] : (rd_pend ? dout_sel : '0);
    assign m_last  = !fifo_empty ? fifo_last[rd_ptr] : (rd_pend & pend_last);

    assign beat  = m_valid && m_ready;
    assign issue = (state == S_UNLOAD) && !rd_done && ((fifo_cnt + 2'(rd_pend)) < 2'd2);
    assign push  = rd_pend && !(fifo_empty && beat);
    assign pop   = beat && !fifo_empty;
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            bank_q     <= 1'b0;
            idx        <= '0;
            load_last  <= 1'b0;
            rd_pend    <= 1'b0;
            pend_last  <= 1'b0;
            rd_done    <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            s_ready    <= 1'b0;
            ntt_enable <= 1'b0;
            ntt_mode   <= 1'b0;
            bram_owner <= 1'b0;
            io_bank    <= 1'b0;
            io_addr    <= '0;
            io_we      <= 1'b0;
            io_din     <= '0;
            op_done    <= 1'b0;
        end else begin
            op_done <= 1'b0;
            rd_pend <= issue;
            if (issue) begin
                pend_last <= (io_addr == LAST_ADDR);
            end
            if (push) begin
                fifo_data[wr_ptr] <= dout_sel;
                fifo_last[wr_ptr] <= pend_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);

            case (state)
                S_IDLE: begin
                    if (op_start) begin
                        mode_q     <= op_mode;
                        bank_q     <= op_result_bank;
                        idx        <= '0;
                        s_ready    <= 1'b1;
                        bram_owner <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    io_we <= 1'b0;
                    if (s_valid && s_ready) begin
                        io_we   <= 1'b1;
                        io_bank <= 1'b0;
                        io_addr <= idx;
                        io_din  <= s_red;
                        idx     <= idx + ADDR_WIDTH'(1);
                        if (idx == LAST_ADDR) begin
                            s_ready   <= 1'b0;
                            load_last <= 1'b1;
                        end
                    end
                    // load_last is set together with the final write strobe
                    if (load_last) begin
                        load_last  <= 1'b0;
                        bram_owner <= 1'b0;
                        ntt_enable <= 1'b1;
                        ntt_mode   <= mode_q;
                        io_addr    <= '0;
                        io_din     <= '0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    ntt_enable <= 1'b0;
                    ntt_mode   <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (ntt_done) begin
                        idx        <= '0;
                        io_addr    <= '0;
                        io_bank    <= bank_q;
                        rd_done    <= 1'b0;
                        bram_owner <= 1'b1;
                        state      <= S_UNLOAD;
                    end
                end
                S_UNLOAD: begin
                    if (issue) begin
                        if (io_addr == LAST_ADDR) begin
                            rd_done <= 1'b1;
                        end else begin
                            io_addr <= io_addr + ADDR_WIDTH'(1);
                        end
                    end
                    if (beat && m_last) begin
                        op_done    <= 1'b1;
                        bram_owner <= 1'b0;
                        io_bank    <= 1'b0;
                        io_addr    <= '0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_poly_io.sv
// tb/tb_ntt_poly_io.sv - scoreboard bench for ntt_poly_io
module tb_ntt_poly_io;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          op_start, op_mode, op_result_bank;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          ntt_enable, ntt_mode, ntt_done;
    logic          bram_owner, io_bank, io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_din, io_dout0, io_dout1;
    logic          m_valid, m_ready, m_last, busy, op_done;
    logic [DW-1:0] m_data;

    logic stub_done, poke_done;
    assign ntt_done = stub_done | poke_done;

    always #5 clk = ~clk;

    ntt_poly_io #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .Q(3329)) dut (
        .clk(clk), .rst(rst),
        .op_start(op_start), .op_mode(op_mode), .op_result_bank(op_result_bank),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .ntt_enable(ntt_enable), .ntt_mode(ntt_mode), .ntt_done(ntt_done),
        .bram_owner(bram_owner), .io_bank(io_bank), .io_addr(io_addr),
        .io_we(io_we), .io_din(io_din), .io_dout0(io_dout0), .io_dout1(io_dout1),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .op_done(op_done)
    );

    logic [35:0] outs;
    assign outs = {s_ready, ntt_enable, ntt_mode, bram_owner, io_bank, io_addr, io_we,
                   io_din, m_valid, m_data, m_last, busy, op_done};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int enables = 0;
    int last_we_cyc = 0, done_cyc = 0, op_done_cyc = 0, first_mv_cyc = 0;
    int wr_exp_addr = 0;
    logic exp_mode = 1'b0;
    logic prev_mv = 1'b0, prev_stall = 1'b0, prev_en = 1'b0, prev_last_beat = 1'b0;

    logic [DW-1:0]    bank0 [N];
    logic [DW-1:0]    bank1 [N];
    logic [AW+DW-1:0] wr_q [$];
    logic [DW:0]      out_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (io_we && !io_bank) bank0[io_addr] <= io_din;
        io_dout0 <= bank0[io_addr];
        io_dout1 <= bank1[io_addr];
    end

    initial begin
        stub_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ntt_enable) begin
                repeat (10) @(posedge clk);
                #1 stub_done = 1'b1;
                done_cyc = cyc;
                @(posedge clk);
                #1 stub_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_mv = 1'b0; prev_stall = 1'b0; prev_en = 1'b0; prev_last_beat = 1'b0;
        end else begin
            chk("op_done_pulse", op_done, prev_last_beat);
            prev_last_beat = 1'b0;
            if (io_we) begin
                chk("we_owner", bram_owner, 1);
                chk("we_bank", io_bank, 0);
                if (wr_q.size() == 0) chk("wr_unexpected", 64'(wr_q.size()), 1);
                else chk("write", {io_addr, io_din}, wr_q.pop_front());
                last_we_cyc = cyc;
            end
            if (ntt_enable) begin
                chk("enable_mode", ntt_mode, exp_mode);
                chk("enable_single", prev_en, 0);
                chk("enable_after_write", 64'(cyc), 64'(last_we_cyc + 1));
                enables++;
            end
            if (prev_stall) chk("stall_valid", m_valid, 1);
            if (m_valid && !prev_mv) first_mv_cyc = cyc;
            if (m_valid) begin
                if (out_q.size() == 0) chk("out_unexpected", 64'(out_q.size()), 1);
                else begin
                    chk("out_beat", {m_last, m_data}, out_q[0]);
                    if (m_ready) prev_last_beat = out_q.pop_front() >> DW;
                end
            end
            if (op_done) op_done_cyc = cyc;
            prev_mv    = m_valid;
            prev_stall = m_valid && !m_ready;
            prev_en    = ntt_enable;
        end
    end

    task automatic start_op(input logic m, input logic b);
        op_start = 1'b1; op_mode = m; op_result_bank = b;
        exp_mode = m; wr_exp_addr = 0;
        @(posedge clk);
        #1 op_start = 1'b0; op_mode = ~m; op_result_bank = ~b;
        chk("load_s_ready", s_ready, 1);
        chk("load_busy", busy, 1);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e, input bit to_out);
        bit acc = 1'b0;
        s_data = d; s_valid = 1'b1;
        wr_q.push_back({wr_exp_addr[AW-1:0], e});
        if (to_out) out_q.push_back({(wr_exp_addr == N - 1), e});
        wr_exp_addr++;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ready) begin acc = 1'b1; break; end
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
        chk("s_accept", acc, 1);
    endtask

    task automatic wait_done(input bit tog);
        bit found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (op_done) begin found = 1'b1; break; end
            @(posedge clk);
            #1 if (tog) m_ready = ~m_ready;
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        chk("op_done_seen", found, 1);
    endtask

    task automatic push_out(input logic [DW-1:0] v, input bit last);
        out_q.push_back({last, v});
    endtask

    initial begin
        bit found;
        rst = 1'b0; op_start = 1'b0; op_mode = 1'b0; op_result_bank = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1; poke_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            bank0[i] = '0;
            bank1[i] = DW'(10 * (i + 1));
        end
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", outs, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 chk("idle_outputs", outs, 0);

        poke_done = 1'b1;
        @(posedge clk);
        #1 poke_done = 1'b0;
        @(posedge clk);
        #1 chk("idle_done_ignored", busy, 0);
        chk("idle_no_enable", enables, 0);

        start_op(1'b0, 1'b0);
        send(0, 0, 1); send(2, 2, 1); send(4, 4, 1); send(6, 6, 1);
        wait_done(0);
        chk("t1_done_latency", 64'(op_done_cyc - done_cyc), N + 2);
        chk("t1_first_valid", 64'(first_mv_cyc - done_cyc), 2);
        chk("t1_enables", enables, 1);

        start_op(1'b0, 1'b0);
        send(3328, 3328, 1); send(3329, 0, 1); send(4095, 766, 1); send(0, 0, 1);
        wait_done(0);

        push_out(10, 0); push_out(20, 0); push_out(30, 0); push_out(40, 1);
        start_op(1'b1, 1'b1);
        send(100, 100, 0); send(200, 200, 0); send(300, 300, 0); send(400, 400, 0);
        wait_done(0);
        chk("t3_enables", enables, 3);

        m_ready = 1'b0;
        start_op(1'b0, 1'b0);
        send(5, 5, 1); send(6, 6, 1); send(7, 7, 1); send(8, 8, 1);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m_valid) begin found = 1'b1; break; end
        end
        chk("t4_valid_seen", found, 1);
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b1;
        wait_done(1);

        start_op(1'b0, 1'b0);
        send(11, 11, 1);
        op_start = 1'b1; op_mode = 1'b1; op_result_bank = 1'b1;
        @(posedge clk);
        #1 op_start = 1'b0;
        @(posedge clk);
        #1 send(12, 12, 1);
        repeat (3) @(posedge clk);
        #1 send(13, 13, 1); send(14, 14, 1);
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ntt_enable) begin found = 1'b1; break; end
        end
        chk("t5_enable_seen", found, 1);
        @(posedge clk);
        #1 op_start = 1'b1; op_mode = 1'b1; op_result_bank = 1'b1;
        @(posedge clk);
        #1 op_start = 1'b0;
        wait_done(0);
        @(posedge clk);
        #1 chk("t5_back_idle", busy, 0);
        chk("t5_enables", enables, 5);

        start_op(1'b0, 1'b0);
        send(21, 21, 1); send(22, 22, 1);
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs", outs, 0);
        wr_q.delete();
        out_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 start_op(1'b0, 1'b0);
        send(31, 31, 1); send(32, 32, 1); send(33, 33, 1); send(34, 34, 1);
        wait_done(0);

        chk("queues_drained", 64'(wr_q.size() + out_q.size()), 0);
        chk("enable_total", enables, 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
